// File: rtl/wishbone_initiator_bfm_pkg.sv
// ---------------------------------------------------------------------------
// wb_initiator_pkg
// Shared definitions for the Wishbone classic single-beat initiator:
//   - default address/data widths
//   - initiator FSM state encoding
//   - request/response record types (default widths) for drivers/benches
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package wb_initiator_pkg;

    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic                     we;
        logic [WB_ADDR_WIDTH-1:0] adr;
        logic [WB_DATA_WIDTH-1:0] dat;
    } wb_req_t;

    typedef struct packed {
        logic [WB_DATA_WIDTH-1:0] dat;
    } wb_rsp_t;

endpackage

// File: rtl/wishbone_initiator_bfm_if.sv
// ---------------------------------------------------------------------------
// wishbone_initiator_bfm_if
// Bundles the request channel, the response strobe and the Wishbone bus.
//   master modport : the initiator core (drives bus + req_ready + rsp_*)
//   slave  modport : the environment (drives dat_r/ack + request fields)
// Signals:
//   adr, dat_w, stb, cyc, we   Wishbone outputs of the initiator
//   dat_r, ack                 Wishbone inputs from the slave
//   req_valid/req_ready        request handshake; req_we/req_adr/req_dat
//   rsp_valid, rsp_dat         one-cycle completion strobe and read data
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface wishbone_initiator_bfm_if
    import wb_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat_r;
    logic [DATA_WIDTH-1:0] dat_w;
    logic                  stb;
    logic                  cyc;
    logic                  ack;
    logic                  we;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_adr;
    logic [DATA_WIDTH-1:0] req_dat;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_dat;

    modport master (
        output adr, dat_w, stb, cyc, we, req_ready, rsp_valid, rsp_dat,
        input  dat_r, ack, req_valid, req_we, req_adr, req_dat
    );

    modport slave (
        input  adr, dat_w, stb, cyc, we, req_ready, rsp_valid, rsp_dat,
        output dat_r, ack, req_valid, req_we, req_adr, req_dat
    );

endinterface

// File: rtl/wishbone_initiator_bfm.sv
// ---------------------------------------------------------------------------
// wishbone_initiator_bfm
// Wishbone classic single-beat initiator. A request accepted on the
// valid/ready channel becomes one bus cycle; the cycle ends on the first
// ack, after which a one-cycle rsp_valid carries the read data (0 for
// writes). A DONE state forces at least one cycle with cyc low between
// transactions.
// Ports:
//   clock  : bus clock, all logic on posedge
//   reset  : synchronous, active-high
//   bus    : wishbone_initiator_bfm_if.master (bus, request, response)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module wishbone_initiator_bfm
    import wb_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    wishbone_initiator_bfm_if.master  bus
);

    wb_state_e             state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_w_q, dat_w_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_w_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_w_q     <= dat_w_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_w_d     = dat_w_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    // write data is latched for reads too, so the bus
                    // always shows what the requester supplied
                    adr_d   = bus.req_adr;
                    dat_w_d = bus.req_dat;
                    we_d    = bus.req_we;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (bus.ack) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = we_q ? '0 : bus.dat_r;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gated by reset so a request presented during reset is never
    // reported as accepted.
    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.cyc       = cyc_q;
    assign bus.stb       = stb_q;
    assign bus.we        = we_q;
    assign bus.adr       = adr_q;
    assign bus.dat_w     = dat_w_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;

endmodule

// File: tb/tb_wishbone_initiator_bfm.sv
// ---------------------------------------------------------------------------
// tb_wishbone_initiator_bfm
// Directed bench for the Wishbone initiator. A small slave model acks a
// programmable number of cycles after it first sees stb; dat_r is either
// a fixed pattern or a loopback of dat_w. write()/read() are the thin
// request-channel wrappers used by higher-level test code.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wishbone_initiator_bfm;
    import wb_initiator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wishbone_initiator_bfm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wishbone_initiator_bfm #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;

    logic ack_r     = 1'b0;
    logic stray_ack = 1'b0;
    logic loopback  = 1'b0;
    int   ack_delay = 1;

    assign bus.ack   = ack_r | stray_ack;
    assign bus.dat_r = loopback ? bus.dat_w : 32'hA5A5_A5A5;

    initial forever #5 clk = ~clk;

    // Slave: counts cycles with stb seen, raises ack once the count reaches
    // ack_delay, drops it the following cycle.
    initial begin : slave
        int   cnt;
        logic seen;
        logic ackd;
        cnt = 0;
        forever begin
            @(negedge clk);
            seen = bus.cyc && bus.stb;
            ackd = ack_r;
            @(posedge clk);
            #1;
            if (ackd) begin
                ack_r = 1'b0;
                cnt   = 0;
            end else if (seen) begin
                cnt++;
                if (cnt >= ack_delay) ack_r = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output bit timed_out);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = w;
        bus.req_adr   = a;
        bus.req_dat   = d;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        timed_out = !bus.rsp_valid;
        rd        = bus.rsp_dat;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, output bit timed_out);
        logic [31:0] unused_rd;
        bus_txn(1'b1, a, d, unused_rd, timed_out);
    endtask

    task automatic read(input logic [31:0] a, output logic [31:0] d, output bit timed_out);
        bus_txn(1'b0, a, 32'h0, d, timed_out);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_adr   = 32'h99;
        bus.req_dat   = 32'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.cyc, bus.stb, bus.we, bus.rsp_valid, bus.req_ready, bus.adr, bus.dat_w, bus.rsp_dat}
                !== {5'b0, 32'h0, 32'h0, 32'h0}) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got cyc=%b stb=%b we=%b rsp_valid=%b ready=%b adr=%h dat_w=%h, required all 0",
                         i, bus.cyc, bus.stb, bus.we, bus.rsp_valid, bus.req_ready, bus.adr, bus.dat_w);
            end
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        @(negedge clk);
        vectors++;
        if ({bus.cyc, bus.stb, bus.we, bus.rsp_valid, bus.adr, bus.dat_w} !== {4'b0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_first_idle: got cyc=%b stb=%b we=%b rsp_valid=%b adr=%h dat_w=%h, required all 0",
                     bus.cyc, bus.stb, bus.we, bus.rsp_valid, bus.adr, bus.dat_w);
        end
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle_ready: got %b, required 1", bus.req_ready);
        end
    endtask

    task automatic test_write();
        int cycles;
        ack_delay = 1;
        loopback  = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_adr   = 32'h10;
        bus.req_dat   = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        cycles = 0;
        while (bus.cyc && cycles < 20) begin
            vectors++;
            if ({bus.stb, bus.we, bus.rsp_valid, bus.req_ready, bus.adr, bus.dat_w}
                !== {4'b1100, 32'h10, 32'hDEAD_BEEF}) begin
                miscompares++;
                $display("FAIL wr_bus_hold: got stb=%b we=%b rsp_valid=%b ready=%b adr=%h dat_w=%h, required 1 1 0 0 00000010 deadbeef",
                         bus.stb, bus.we, bus.rsp_valid, bus.req_ready, bus.adr, bus.dat_w);
            end
            cycles++;
            @(negedge clk);
        end
        vectors++;
        if (cycles !== 2) begin
            miscompares++;
            $display("FAIL wr_stb_cycles: got %0d, required 2", cycles);
        end
        vectors++;
        if ({bus.rsp_valid, bus.stb, bus.we, bus.rsp_dat} !== {3'b100, 32'h0}) begin
            miscompares++;
            $display("FAIL wr_rsp: got rsp_valid=%b stb=%b we=%b rsp_dat=%h, required 1 0 0 00000000",
                     bus.rsp_valid, bus.stb, bus.we, bus.rsp_dat);
        end
        @(negedge clk);
        vectors++;
        if ({bus.rsp_valid, bus.cyc, bus.adr, bus.dat_w} !== {2'b00, 32'h10, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL wr_after: got rsp_valid=%b cyc=%b adr=%h dat_w=%h, required 0 0 00000010 deadbeef",
                     bus.rsp_valid, bus.cyc, bus.adr, bus.dat_w);
        end
    endtask

    task automatic test_read();
        int cycles;
        ack_delay = 1;
        loopback  = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_adr   = 32'h20;
        bus.req_dat   = 32'h1234_5678;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        cycles = 0;
        while (bus.cyc && cycles < 20) begin
            vectors++;
            if ({bus.stb, bus.we, bus.rsp_valid, bus.adr, bus.dat_w} !== {3'b100, 32'h20, 32'h1234_5678}) begin
                miscompares++;
                $display("FAIL rd_bus_hold: got stb=%b we=%b rsp_valid=%b adr=%h dat_w=%h, required 1 0 0 00000020 12345678",
                         bus.stb, bus.we, bus.rsp_valid, bus.adr, bus.dat_w);
            end
            cycles++;
            @(negedge clk);
        end
        vectors++;
        if (cycles !== 2) begin
            miscompares++;
            $display("FAIL rd_stb_cycles: got %0d, required 2", cycles);
        end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_dat} !== {1'b1, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL rd_rsp: got rsp_valid=%b rsp_dat=%h, required 1 12345678", bus.rsp_valid, bus.rsp_dat);
        end
        @(negedge clk);
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_rsp_pulse: got rsp_valid=%b, required 0", bus.rsp_valid);
        end
        loopback = 1'b0;
    endtask

    task automatic test_long_ack();
        int cycles;
        ack_delay = 5;
        loopback  = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_adr   = 32'h30;
        bus.req_dat   = 32'hCAFE_F00D;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        cycles = 0;
        while (bus.cyc && cycles < 30) begin
            vectors++;
            if ({bus.stb, bus.we, bus.rsp_valid, bus.adr, bus.dat_w} !== {3'b110, 32'h30, 32'hCAFE_F00D}) begin
                miscompares++;
                $display("FAIL long_hold[%0d]: got stb=%b we=%b rsp_valid=%b adr=%h dat_w=%h, required 1 1 0 00000030 cafef00d",
                         cycles, bus.stb, bus.we, bus.rsp_valid, bus.adr, bus.dat_w);
            end
            cycles++;
            @(negedge clk);
        end
        vectors++;
        if (cycles !== 6) begin
            miscompares++;
            $display("FAIL long_stb_cycles: got %0d, required 6", cycles);
        end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_dat} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL long_rsp: got rsp_valid=%b rsp_dat=%h, required 1 00000000", bus.rsp_valid, bus.rsp_dat);
        end
        @(negedge clk);
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL long_rsp_pulse: got rsp_valid=%b, required 0", bus.rsp_valid);
        end
        ack_delay = 1;
    endtask

    task automatic test_ack_outside_bus();
        @(negedge clk);
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.cyc, bus.stb, bus.rsp_valid, bus.req_ready} !== 4'b0001) begin
                miscompares++;
                $display("FAIL stray_ack[%0d]: got cyc=%b stb=%b rsp_valid=%b ready=%b, required 0 0 0 1",
                         i, bus.cyc, bus.stb, bus.rsp_valid, bus.req_ready);
            end
        end
        stray_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        wb_req_t     txn [2];
        logic [31:0] exp_rsp [2];
        int          acc_t [2];
        int          idx, rsp_cnt, cyc_low, gap;
        logic        acc_flag, prev_cyc, was_high;
        txn[0]     = '{we: 1'b1, adr: 32'h40, dat: 32'h1111_1111};
        txn[1]     = '{we: 1'b0, adr: 32'h44, dat: 32'h2222_2222};
        exp_rsp[0] = 32'h0;
        exp_rsp[1] = 32'h2222_2222;
        acc_t[0] = -1;
        acc_t[1] = -1;
        idx = 0; rsp_cnt = 0; cyc_low = 0; gap = -1;
        acc_flag = 1'b0; prev_cyc = 1'b0; was_high = 1'b0;
        ack_delay = 1;
        loopback  = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = txn[0].we;
        bus.req_adr   = txn[0].adr;
        bus.req_dat   = txn[0].dat;
        for (int t = 0; t < 40 && rsp_cnt < 2; t++) begin
            if (acc_flag) begin
                acc_flag = 1'b0;
                idx++;
                if (idx < 2) begin
                    bus.req_we  = txn[idx].we;
                    bus.req_adr = txn[idx].adr;
                    bus.req_dat = txn[idx].dat;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            vectors++;
            if (bus.req_ready !== (!bus.cyc && !bus.rsp_valid)) begin
                miscompares++;
                $display("FAIL b2b_ready_idle[%0d]: got ready=%b, required %b", t, bus.req_ready, !bus.cyc && !bus.rsp_valid);
            end
            if (bus.rsp_valid) begin
                vectors++;
                if (bus.rsp_dat !== exp_rsp[rsp_cnt]) begin
                    miscompares++;
                    $display("FAIL b2b_rsp[%0d]: got %h, required %h", rsp_cnt, bus.rsp_dat, exp_rsp[rsp_cnt]);
                end
                rsp_cnt++;
            end
            if (bus.cyc) begin
                if (!prev_cyc && was_high) gap = cyc_low;
                cyc_low  = 0;
                was_high = 1'b1;
            end else if (was_high) begin
                cyc_low++;
            end
            prev_cyc = bus.cyc;
            if (bus.req_ready && bus.req_valid && idx < 2) begin
                acc_flag   = 1'b1;
                acc_t[idx] = t;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        vectors++;
        if (rsp_cnt !== 2) begin
            miscompares++;
            $display("FAIL b2b_rsp_count: got %0d, required 2", rsp_cnt);
        end
        vectors++;
        if (gap < 1) begin
            miscompares++;
            $display("FAIL b2b_cyc_gap: got %0d idle cycles, required at least 1", gap);
        end
        vectors++;
        if (acc_t[1] - acc_t[0] !== 4) begin
            miscompares++;
            $display("FAIL b2b_accept_spacing: got %0d, required 4", acc_t[1] - acc_t[0]);
        end
        loopback = 1'b0;
    endtask

    task automatic test_reset_mid_bus();
        bit          to;
        logic [31:0] rd;
        logic        bad;
        ack_delay = 5;
        loopback  = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_adr   = 32'h50;
        bus.req_dat   = 32'h55AA_55AA;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        @(negedge clk);
        vectors++;
        if ({bus.cyc, bus.stb} !== 2'b11) begin
            miscompares++;
            $display("FAIL rmb_in_bus: got cyc=%b stb=%b, required 1 1", bus.cyc, bus.stb);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.cyc, bus.stb, bus.we, bus.rsp_valid, bus.adr, bus.dat_w, bus.rsp_dat}
            !== {4'b0, 32'h0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL rmb_abort: got cyc=%b stb=%b we=%b rsp_valid=%b adr=%h dat_w=%h, required all 0",
                     bus.cyc, bus.stb, bus.we, bus.rsp_valid, bus.adr, bus.dat_w);
        end
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.cyc !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL rmb_no_rsp: got activity=%b after abort, required 0", bad);
        end
        ack_delay = 1;
        write(32'h60, 32'h0BAD_F00D, to);
        vectors++;
        if ({to, bus.rsp_dat, bus.adr, bus.dat_w} !== {1'b0, 32'h0, 32'h60, 32'h0BAD_F00D}) begin
            miscompares++;
            $display("FAIL rmb_write_after: got timeout=%b rsp_dat=%h adr=%h dat_w=%h, required 0 00000000 00000060 0badf00d",
                     to, bus.rsp_dat, bus.adr, bus.dat_w);
        end
        read(32'h64, rd, to);
        vectors++;
        if ({to, rd, bus.adr} !== {1'b0, 32'hA5A5_A5A5, 32'h64}) begin
            miscompares++;
            $display("FAIL rmb_read_after: got timeout=%b data=%h adr=%h, required 0 a5a5a5a5 00000064", to, rd, bus.adr);
        end
    endtask

    initial begin : main
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        test_reset();
        test_write();
        test_read();
        test_long_ack();
        test_ack_outside_bus();
        test_back_to_back();
        test_reset_mid_bus();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
